// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the parametrised synchronous FIFO.
//   ptr_w(depth) - pointer width for a given depth (at least 1 bit)
//   cnt_w(depth) - occupancy counter width, able to hold 0..depth
//   fifo_err_t   - sticky error flag pair {overflow, underflow}
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle of the synchronous FIFO.
//   master modport - the FIFO user: drives data_in, push, pop, clear_err
//   slave modport  - the FIFO itself: drives data_out, status flags, count,
//                    sticky overflow/underflow
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 5,
  parameter int FIFO_WIDTH = 8
);
  logic [FIFO_WIDTH-1:0]            data_in;
  logic                             push;
  logic                             pop;
  logic                             clear_err;
  logic [FIFO_WIDTH-1:0]            data_out;
  logic                             empty;
  logic                             full;
  logic                             almost_empty;
  logic                             almost_full;
  logic [cnt_w(FIFO_DEPTH)-1:0]     count;
  logic                             overflow;
  logic                             underflow;

  modport master (
    output data_in, push, pop, clear_err,
    input  data_out, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  data_in, push, pop, clear_err,
    output data_out, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are never reset.
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised synchronous FIFO with arbitrary depth,
// occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
//   clk   - clock, all logic on posedge
//   reset - synchronous, active-low
//   bus   - sync_fifo_param_if.slave: data_in/push/pop/clear_err in,
//           data_out/empty/full/almost_empty/almost_full/count/
//           overflow/underflow out
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (data_out shows the head word combinationally, 0 while empty). Without
// it, data_out is registered and updates one cycle after an accepted pop.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 5,
  parameter int FIFO_WIDTH = 8,
  parameter int AF_THRESH  = 4,
  parameter int AE_THRESH  = 1
) (
  input  logic               clk,
  input  logic               reset,
  sync_fifo_param_if.slave   bus
);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_C    = cnt_t'(AE_THRESH);
  localparam ptr_t LAST_C  = ptr_t'(FIFO_DEPTH - 1);

  // Pointers wrap explicitly so depth need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_C) ? '0 : p + ptr_t'(1);
  endfunction

  ptr_t                  wr_ptr_q, rd_ptr_q;
  cnt_t                  count_q;
  fifo_err_t             err_q, err_new;
  logic                  empty_w, full_w;
  logic                  push_ok, pop_ok;
  logic [FIFO_WIDTH-1:0] rd_data;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push paired with a pop; an empty FIFO never honours the pop.
  always_comb begin
    pop_ok  = bus.pop & ~empty_w;
    push_ok = bus.push & (~full_w | pop_ok);
    err_new = '0;
    err_new.overflow  = bus.push & ~push_ok;
    err_new.underflow = bus.pop & empty_w;
  end

  fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
      // A fresh error in the same cycle as clear_err keeps its flag set.
      err_q <= (bus.clear_err ? fifo_err_t'('0) : err_q) | err_new;
    end
  end

  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.count        = count_q;
  assign bus.overflow     = err_q.overflow;
  assign bus.underflow    = err_q.underflow;

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty_w ? '0 : rd_data;
`else
  // ---- stage p1: registered read data ----
  logic [FIFO_WIDTH-1:0] dout_p1;

  always_ff @(posedge clk) begin
    if (!reset)      dout_p1 <= '0;
    else if (pop_ok) dout_p1 <= rd_data;
  end

  assign bus.data_out = dout_p1;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param (DEPTH=5, WIDTH=8,
// AF=4, AE=1). A queue holds the words the FIFO should contain; every step
// compares count, flags, stickies and data_out against it.
module tb_sync_fifo_param;
  localparam int DEPTH = 5;
  localparam int WIDTH = 8;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH)) bus ();

  sync_fifo_param #(
    .FIFO_DEPTH (DEPTH),
    .FIFO_WIDTH (WIDTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] last_dout;
  logic             ov_m, un_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [WIDTH-1:0] exp_d;
    int               sz;
    sz = sb_q.size();
`ifdef FIFO_FWFT_EN
    exp_d = (sz == 0) ? '0 : sb_q[0];
`else
    exp_d = last_dout;
`endif
    chk({tag, ".count"},     32'(bus.count),        32'(sz));
    chk({tag, ".empty"},     32'(bus.empty),        32'(sz == 0));
    chk({tag, ".full"},      32'(bus.full),         32'(sz == DEPTH));
    chk({tag, ".a_empty"},   32'(bus.almost_empty), 32'(sz <= AE));
    chk({tag, ".a_full"},    32'(bus.almost_full),  32'(sz >= AF));
    chk({tag, ".overflow"},  32'(bus.overflow),     32'(ov_m));
    chk({tag, ".underflow"}, 32'(bus.underflow),    32'(un_m));
    chk({tag, ".data_out"},  32'(bus.data_out),     32'(exp_d));
  endtask

  // One clock of stimulus; the scoreboard is updated with what should be
  // accepted, then the DUT state is compared just after the edge.
  task automatic step(input string tag, input logic ps, input logic pp,
                      input logic [WIDTH-1:0] d, input logic clr);
    logic ok_pop, ok_push;
    bus.push      = ps;
    bus.pop       = pp;
    bus.data_in   = d;
    bus.clear_err = clr;
    ok_pop  = pp && (sb_q.size() != 0);
    ok_push = ps && ((sb_q.size() < DEPTH) || ok_pop);
    ov_m = (clr ? 1'b0 : ov_m) | (ps && !ok_push);
    un_m = (clr ? 1'b0 : un_m) | (pp && (sb_q.size() == 0));
    if (ok_pop)  last_dout = sb_q.pop_front();
    if (ok_push) sb_q.push_back(d);
    @(posedge clk);
    #1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.clear_err = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear_err = 1'b0; bus.data_in = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    last_dout = '0;
    ov_m = 1'b0;
    un_m = 1'b0;
    check_state(tag);
  endtask

  logic [WIDTH-1:0] seq5 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

  initial begin
    reset = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear_err = 1'b0; bus.data_in = '0;
    last_dout = '0; ov_m = 1'b0; un_m = 1'b0;
    @(posedge clk);
    do_reset("rst0");

    // Fill to full then drain in order.
    for (int i = 0; i < 5; i++) step("t1.push", 1'b1, 1'b0, seq5[i], 1'b0);
    for (int i = 0; i < 5; i++) step("t1.pop", 1'b0, 1'b1, '0, 1'b0);

    // Push while full is dropped and sets overflow; clear_err clears it.
    for (int i = 0; i < 5; i++) step("t2.fill", 1'b1, 1'b0, seq5[i], 1'b0);
    step("t2.ovf", 1'b1, 1'b0, 8'h11, 1'b0);
    for (int i = 0; i < 5; i++) step("t2.pop", 1'b0, 1'b1, '0, 1'b0);
    step("t2.clr", 1'b0, 1'b0, '0, 1'b1);

    // Pop while empty; push+pop on empty; clear racing a new error.
    step("t3.unf", 1'b0, 1'b1, '0, 1'b0);
    step("t3.pp_empty", 1'b1, 1'b1, 8'h22, 1'b0);
    step("t3.pop22", 1'b0, 1'b1, '0, 1'b0);
    step("t3.clr_vs_unf", 1'b0, 1'b1, '0, 1'b1);
    step("t3.clr", 1'b0, 1'b0, '0, 1'b1);

    // Pointer wrap-around.
    for (int i = 0; i < 3; i++) step("t4.push3", 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 3; i++) step("t4.pop3", 1'b0, 1'b1, '0, 1'b0);
    for (int i = 1; i <= 5; i++) step("t4.push5", 1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) step("t4.pop5", 1'b0, 1'b1, '0, 1'b0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 5; i++) step("t5.fill", 1'b1, 1'b0, seq5[i], 1'b0);
    step("t5.pp_full", 1'b1, 1'b1, 8'h66, 1'b0);
    for (int i = 0; i < 5; i++) step("t5.drain", 1'b0, 1'b1, '0, 1'b0);

    // Reset mid-operation, with sticky flags set beforehand.
    step("t6.unf", 1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 3; i++) step("t6.push", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    step("t6.pop", 1'b0, 1'b1, '0, 1'b0);
    step("t6.push", 1'b1, 1'b0, 8'h43, 1'b0);
    do_reset("t6.rst");
    step("t6.push77", 1'b1, 1'b0, 8'h77, 1'b0);
    step("t6.pop77", 1'b0, 1'b1, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
